ram_arbiter_2x1: RTL and testbench

RAM_ARBITER_2X1 -- requirements
Module: ram_arbiter_2x1

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_arb_rr_pick.sv | 25 ++
 rtl/ram_arbiter_2x1.sv | 138 +++++++++++++
 tb/tb_ram_arbiter_2x1.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the two-master RAM arbiter: master ids and lock-owner encoding.
// Lock encodings are only consumed when the design is built with RAM_ARB_LOCK_EN.
package ram_arb_pkg;

    typedef logic master_id_t;

    localparam master_id_t MASTER_0 = 1'b0;
    localparam master_id_t MASTER_1 = 1'b1;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_M0   = 2'd1,
        LOCK_M1   = 2'd2
    } lock_owner_t;

    // Debug state word: {lock owner, last served}.
    localparam int DBG_W = 3;

endpackage

// File: rtl/ram_arb_rr_pick.sv
// Combinational grant selection for two masters.
// A requesting lock owner wins outright; otherwise the master not served last wins.
module ram_arb_rr_pick
    import ram_arb_pkg::*;
(
    input  logic [1:0]  req_i,
    input  master_id_t  last_served_i,
    input  lock_owner_t lock_owner_i,
    output logic [1:0]  grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (lock_owner_i == LOCK_M0 && req_i[0]) begin
            grant_o = 2'b01;
        end else if (lock_owner_i == LOCK_M1 && req_i[1]) begin
            grant_o = 2'b10;
        end else if (req_i == 2'b11) begin
            grant_o = (last_served_i == MASTER_1) ? 2'b01 : 2'b10;
        end else begin
            grant_o = req_i;
        end
    end

endmodule

// File: rtl/ram_arbiter_2x1.sv
// Two-master to one zero-latency RAM arbiter, round-robin with optional bus lock.
// Define RAM_ARB_LOCK_EN to add m0_lock/m1_lock and the lock-owner register.
module ram_arbiter_2x1
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_writedata,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_waitrequest,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_waitrequest,
`ifdef RAM_ARB_LOCK_EN
    input  logic                  m0_lock,
    input  logic                  m1_lock,
`endif
    output logic [ADDR_WIDTH-1:0] s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_WIDTH-1:0] s_writedata,
    input  logic [DATA_WIDTH-1:0] s_readdata,
    output logic [DBG_W-1:0]      dbg_state_o
);

    // Handshake: a master's access completes in the cycle it requests with
    // waitrequest=0; while waitrequest=1 it must hold address, read, write and
    // writedata unchanged. Requests are gated by rst_n so that an asserted reset
    // kills any in-flight access combinationally and nothing reaches the RAM.
    logic       m0_req;
    logic       m1_req;
    logic       m0_rd_eff;
    logic       m1_rd_eff;
    logic [1:0] grant;

    master_id_t  last_q;
    master_id_t  last_d;
    lock_owner_t lock_cur;

    assign m0_req    = rst_n & (m0_read | m0_write);
    assign m1_req    = rst_n & (m1_read | m1_write);
    assign m0_rd_eff = m0_read & ~m0_write;
    assign m1_rd_eff = m1_read & ~m1_write;

    ram_arb_rr_pick u_pick (
        .req_i         ({m1_req, m0_req}),
        .last_served_i (last_q),
        .lock_owner_i  (lock_cur),
        .grant_o       (grant)
    );

    always_comb begin
        s_address   = '0;
        s_read      = 1'b0;
        s_write     = 1'b0;
        s_writedata = '0;
        if (grant[0]) begin
            s_address   = m0_address;
            s_read      = m0_rd_eff;
            s_write     = m0_write;
            s_writedata = m0_writedata;
        end else if (grant[1]) begin
            s_address   = m1_address;
            s_read      = m1_rd_eff;
            s_write     = m1_write;
            s_writedata = m1_writedata;
        end
    end

    assign m0_waitrequest = m0_req & ~grant[0];
    assign m1_waitrequest = m1_req & ~grant[1];
    assign m0_readdata    = (grant[0] && m0_rd_eff) ? s_readdata : '0;
    assign m1_readdata    = (grant[1] && m1_rd_eff) ? s_readdata : '0;

    always_comb begin
        last_d = last_q;
        if (grant[0]) begin
            last_d = MASTER_0;
        end else if (grant[1]) begin
            last_d = MASTER_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= MASTER_1;
        end else begin
            last_q <= last_d;
        end
    end

`ifdef RAM_ARB_LOCK_EN
    lock_owner_t lock_q;
    lock_owner_t lock_d;

    // Release when the owner drops its lock; only the granted master may claim,
    // and never while the other master still holds the lock.
    always_comb begin
        lock_d = lock_q;
        if (lock_q == LOCK_M0 && !m0_lock) begin
            lock_d = LOCK_NONE;
        end
        if (lock_q == LOCK_M1 && !m1_lock) begin
            lock_d = LOCK_NONE;
        end
        if (grant[0] && m0_lock && lock_q != LOCK_M1) begin
            lock_d = LOCK_M0;
        end
        if (grant[1] && m1_lock && lock_q != LOCK_M0) begin
            lock_d = LOCK_M1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= LOCK_NONE;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign lock_cur = lock_q;
`else
    assign lock_cur = LOCK_NONE;
`endif

    assign dbg_state_o = {lock_cur, last_q};

endmodule

// File: tb/tb_ram_arbiter_2x1.sv
// Bench for ram_arbiter_2x1 with a zero-delay RAM model; covers the lock
// sequence when RAM_ARB_LOCK_EN is defined.
module tb_ram_arbiter_2x1;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int EW = 2 + AW + DW + 2 + 2 * DW;

    typedef struct {
        logic          m0r, m0w, m0l;
        logic [AW-1:0] m0a;
        logic [DW-1:0] m0d;
        logic          m1r, m1w, m1l;
        logic [AW-1:0] m1a;
        logic [DW-1:0] m1d;
        logic [EW-1:0] e;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] m0_address = '0, m1_address = '0;
    logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_waitrequest, m1_waitrequest;
`ifdef RAM_ARB_LOCK_EN
    logic          m0_lock = 1'b0, m1_lock = 1'b0;
`endif
    logic [AW-1:0] s_address;
    logic          s_read, s_write;
    logic [DW-1:0] s_writedata;
    logic [DW-1:0] s_readdata;
    logic [2:0]    dbg_state_o;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [EW-1:0] exp_q[$];
    vec_t          vec_q[$];

    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] obs_sa;
    logic          obs_sr;
    int            n0, n1;

    ram_arbiter_2x1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m0_address     (m0_address),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_writedata   (m0_writedata),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m1_address     (m1_address),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
`ifdef RAM_ARB_LOCK_EN
        .m0_lock        (m0_lock),
        .m1_lock        (m1_lock),
`endif
        .s_address      (s_address),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_writedata    (s_writedata),
        .s_readdata     (s_readdata),
        .dbg_state_o    (dbg_state_o)
    );

    // Clock and zero-delay RAM model.
    always #5 clk = ~clk;

    assign s_readdata = mem[s_address];

    always @(posedge clk) begin
        if (s_write) mem[s_address] <= s_writedata;
    end

    function automatic logic [EW-1:0] ex(input logic sr, input logic sw, input logic [AW-1:0] sa,
                                         input logic [DW-1:0] sd, input logic w0, input logic w1,
                                         input logic [DW-1:0] r0, input logic [DW-1:0] r1);
        return {sr, sw, sa, sd, w0, w1, r0, r1};
    endfunction

    function automatic vec_t mkv(input logic m0r, input logic m0w, input logic m0l,
                                 input logic [AW-1:0] m0a, input logic [DW-1:0] m0d,
                                 input logic m1r, input logic m1w, input logic m1l,
                                 input logic [AW-1:0] m1a, input logic [DW-1:0] m1d,
                                 input logic [EW-1:0] e);
        vec_t v;
        v.m0r = m0r; v.m0w = m0w; v.m0l = m0l; v.m0a = m0a; v.m0d = m0d;
        v.m1r = m1r; v.m1w = m1w; v.m1l = m1l; v.m1a = m1a; v.m1d = m1d;
        v.e = e;
        return v;
    endfunction

    task automatic apply_inputs(input vec_t v);
        m0_read = v.m0r; m0_write = v.m0w; m0_address = v.m0a; m0_writedata = v.m0d;
        m1_read = v.m1r; m1_write = v.m1w; m1_address = v.m1a; m1_writedata = v.m1d;
`ifdef RAM_ARB_LOCK_EN
        m0_lock = v.m0l; m1_lock = v.m1l;
`endif
    endtask

    // Scoreboard: pop the next expected output word and compare.
    task automatic check_cycle(input string name);
        logic [EW-1:0] act;
        logic [EW-1:0] want;
        act = {s_read, s_write, s_address, s_writedata, m0_waitrequest, m1_waitrequest,
               m0_readdata, m1_readdata};
        obs_sa = s_address;
        obs_sr = s_read;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, actual %h", name, act);
        end else begin
            want = exp_q.pop_front();
            if (act !== want) begin
                errors++;
                $display("FAIL %s: actual %h required %h (sr,sw,addr,wdata,wait0,wait1,rd0,rd1)",
                         name, act, want);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, want);
        end
    endtask

    // Drive one cycle just after a rising edge, sample on the falling edge.
    task automatic drive_vec(input vec_t v, input string name);
        apply_inputs(v);
        exp_q.push_back(v.e);
        @(negedge clk);
        check_cycle(name);
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string tag);
        int idx;
        idx = 0;
        while (vec_q.size() > 0) begin
            drive_vec(vec_q.pop_front(), $sformatf("%s[%0d]", tag, idx));
            idx++;
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
        mem[12'h010] <= 16'hAAAA;
        mem[12'h020] <= 16'h5555;

        // Reset with both masters requesting: everything held at reset values.
        apply_inputs(mkv(1, 0, 0, 12'h010, 16'h0, 1, 1, 0, 12'h020, 16'h7777, '0));
        exp_q.push_back(ex(0, 0, '0, '0, 0, 0, '0, '0));
        @(negedge clk);
        check_cycle("reset_outputs");
        check_val("reset_dbg_state", {29'd0, dbg_state_o}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Contention after reset, single-master write/read, read+write, boundaries.
        vec_q.push_back(mkv(1, 0, 0, 12'h010, 16'h0, 1, 0, 0, 12'h020, 16'h0, ex(1, 0, 12'h010, 16'h0, 0, 1, 16'hAAAA, 16'h0)));
        vec_q.push_back(mkv(0, 0, 0, 12'h000, 16'h0, 1, 0, 0, 12'h020, 16'h0, ex(1, 0, 12'h020, 16'h0, 0, 0, 16'h0, 16'h5555)));
        vec_q.push_back(mkv(0, 1, 0, 12'h005, 16'h1234, 0, 0, 0, 12'h000, 16'h0, ex(0, 1, 12'h005, 16'h1234, 0, 0, 16'h0, 16'h0)));
        vec_q.push_back(mkv(1, 0, 0, 12'h005, 16'h0, 0, 0, 0, 12'h000, 16'h0, ex(1, 0, 12'h005, 16'h0, 0, 0, 16'h1234, 16'h0)));
        vec_q.push_back(mkv(1, 1, 0, 12'h00A, 16'hBEEF, 0, 0, 0, 12'h000, 16'h0, ex(0, 1, 12'h00A, 16'hBEEF, 0, 0, 16'h0, 16'h0)));
        vec_q.push_back(mkv(0, 0, 0, 12'h000, 16'h0, 1, 0, 0, 12'h00A, 16'h0, ex(1, 0, 12'h00A, 16'h0, 0, 0, 16'h0, 16'hBEEF)));
        vec_q.push_back(mkv(0, 0, 0, 12'h000, 16'h0, 0, 1, 0, 12'h0FF, 16'h0F0F, ex(0, 1, 12'h0FF, 16'h0F0F, 0, 0, 16'h0, 16'h0)));
        vec_q.push_back(mkv(0, 1, 0, 12'h100, 16'h1111, 0, 1, 0, 12'h101, 16'h2222, ex(0, 1, 12'h100, 16'h1111, 0, 1, 16'h0, 16'h0)));
        vec_q.push_back(mkv(0, 0, 0, 12'h000, 16'h0, 0, 1, 0, 12'h101, 16'h2222, ex(0, 1, 12'h101, 16'h2222, 0, 0, 16'h0, 16'h0)));
        vec_q.push_back(mkv(0, 0, 0, 12'h000, 16'h0, 0, 1, 0, 12'hFFF, 16'hFFFF, ex(0, 1, 12'hFFF, 16'hFFFF, 0, 0, 16'h0, 16'h0)));
        vec_q.push_back(mkv(1, 0, 0, 12'hFFF, 16'h0, 0, 0, 0, 12'h000, 16'h0, ex(1, 0, 12'hFFF, 16'h0, 0, 0, 16'hFFFF, 16'h0)));
        vec_q.push_back(mkv(0, 0, 0, 12'h000, 16'h0, 1, 0, 0, 12'h0FF, 16'h0, ex(1, 0, 12'h0FF, 16'h0, 0, 0, 16'h0, 16'h0F0F)));
        run_table("basic");
        check_val("ram_00A_rw_as_write", {16'd0, mem[12'h00A]}, 32'h0000BEEF);
        check_val("ram_100_m0_write", {16'd0, mem[12'h100]}, 32'h00001111);

        // Sustained contention: strict alternation, starting with m0.
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0)
                drive_vec(mkv(1, 0, 0, 12'h010, 16'h0, 1, 0, 0, 12'h020, 16'h0, ex(1, 0, 12'h010, 16'h0, 0, 1, 16'hAAAA, 16'h0)), $sformatf("sustain[%0d]", i));
            else
                drive_vec(mkv(1, 0, 0, 12'h010, 16'h0, 1, 0, 0, 12'h020, 16'h0, ex(1, 0, 12'h020, 16'h0, 1, 0, 16'h0, 16'h5555)), $sformatf("sustain[%0d]", i));
            if (obs_sr && obs_sa == 12'h010) n0++;
            if (obs_sr && obs_sa == 12'h020) n1++;
        end
        check_val("sustain_m0_grants", n0, 32'd5);
        check_val("sustain_m1_grants", n1, 32'd5);

        // Reset asserted while m0 is granted and m1 waits: abort, no RAM write.
        apply_inputs(mkv(0, 1, 0, 12'h200, 16'hDEAD, 0, 1, 0, 12'h201, 16'hCAFE, '0));
        exp_q.push_back(ex(0, 1, 12'h200, 16'hDEAD, 0, 1, 16'h0, 16'h0));
        @(negedge clk);
        check_cycle("pre_reset_contention");
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(ex(0, 0, '0, '0, 0, 0, '0, '0));
        check_cycle("mid_reset_outputs");
        check_val("mid_reset_dbg_state", {29'd0, dbg_state_o}, 32'd1);
        @(posedge clk);
        #1;
        check_val("reset_aborts_write", {16'd0, mem[12'h200]}, 32'h0);
        rst_n = 1'b1;
        exp_q.push_back(ex(0, 1, 12'h200, 16'hDEAD, 0, 1, 16'h0, 16'h0));
        @(negedge clk);
        check_cycle("post_reset_m0_wins");
        @(posedge clk);
        #1;
        drive_vec(mkv(0, 0, 0, 12'h000, 16'h0, 0, 1, 0, 12'h201, 16'hCAFE, ex(0, 1, 12'h201, 16'hCAFE, 0, 0, 16'h0, 16'h0)), "post_reset_m1");
        check_val("ram_200_after_release", {16'd0, mem[12'h200]}, 32'h0000DEAD);
        check_val("ram_201_after_release", {16'd0, mem[12'h201]}, 32'h0000CAFE);

`ifdef RAM_ARB_LOCK_EN
        // m1 locks for three accesses while m0 (whose lock is ignored) waits.
        vec_q.push_back(mkv(1, 0, 0, 12'h010, 16'h0, 0, 0, 0, 12'h000, 16'h0, ex(1, 0, 12'h010, 16'h0, 0, 0, 16'hAAAA, 16'h0)));
        vec_q.push_back(mkv(1, 0, 1, 12'h010, 16'h0, 1, 0, 1, 12'h020, 16'h0, ex(1, 0, 12'h020, 16'h0, 1, 0, 16'h0, 16'h5555)));
        vec_q.push_back(mkv(1, 0, 1, 12'h010, 16'h0, 1, 0, 1, 12'h020, 16'h0, ex(1, 0, 12'h020, 16'h0, 1, 0, 16'h0, 16'h5555)));
        vec_q.push_back(mkv(1, 0, 1, 12'h010, 16'h0, 1, 0, 0, 12'h020, 16'h0, ex(1, 0, 12'h020, 16'h0, 1, 0, 16'h0, 16'h5555)));
        vec_q.push_back(mkv(1, 0, 0, 12'h010, 16'h0, 1, 0, 0, 12'h020, 16'h0, ex(1, 0, 12'h010, 16'h0, 0, 1, 16'hAAAA, 16'h0)));
        vec_q.push_back(mkv(0, 0, 0, 12'h000, 16'h0, 1, 0, 0, 12'h020, 16'h0, ex(1, 0, 12'h020, 16'h0, 0, 0, 16'h0, 16'h5555)));
        run_table("lock");
`endif

        apply_inputs(mkv(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, '0));
        check_val("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
